// File: rtl/pcpi_pkg.sv
// pcpi_pkg: shared decode constants, unit indices and scheduler state encoding
package pcpi_pkg;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [6:0] F7_EXACT = 7'b0000000;
  localparam logic [6:0] F7_APPROX = 7'b0000001;
  localparam logic [1:0] U_MUL = 2'd0;
  localparam logic [1:0] U_DIV = 2'd1;
  localparam logic [1:0] U_EXACT = 2'd2;
  localparam logic [1:0] U_APPROX = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP = 2'd2,
    S_DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/pcpi_insn_decode.sv
// pcpi_insn_decode: maps a PCPI instruction word to {match, coprocessor index}
module pcpi_insn_decode
  import pcpi_pkg::*;
(
  input  logic [31:0] i_insn,
  output logic        o_match,
  output logic [1:0]  o_sel
);
  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic w_muldiv;
  logic w_exact;
  logic w_approx;
  logic w_unused;
  assign w_opc = i_insn[6:0];
  assign w_f7 = i_insn[31:25];
  assign w_muldiv = w_opc == OPC_OP && w_f7 == F7_MULDIV;
  assign w_exact = w_opc == OPC_CUSTOM0 && w_f7 == F7_EXACT;
  assign w_approx = w_opc == OPC_CUSTOM0 && w_f7 == F7_APPROX;
  assign o_match = w_muldiv | w_exact | w_approx;
  assign o_sel = w_exact ? U_EXACT : w_approx ? U_APPROX : i_insn[14] ? U_DIV : U_MUL;
  assign w_unused = &{1'b0, i_insn[24:15], i_insn[13:7]};
endmodule

// File: rtl/pcpi_sched.sv
// pcpi_sched: dispatches PCPI requests to one of four coprocessors with watchdog and sticky timeout flag
module pcpi_sched
  import pcpi_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pcpi_valid,
  input  logic [31:0]           pcpi_insn,
  output logic                  pcpi_wr,
  output logic [31:0]           pcpi_rd,
  output logic                  pcpi_wait,
  output logic                  pcpi_ready,
  output logic [N_UNITS-1:0]    unit_valid,
  input  logic [N_UNITS-1:0]    unit_wr,
  input  logic [32*N_UNITS-1:0] unit_rd,
  input  logic [N_UNITS-1:0]    unit_wait,
  input  logic [N_UNITS-1:0]    unit_ready,
  output logic                  busy,
  output logic                  err_timeout,
  input  logic                  err_clr
);
  state_t r_state;
  state_t w_state_nxt;
  logic [1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_rd;
  logic r_wr;
  logic r_err;
  logic w_match;
  logic [1:0] w_sel;
  logic w_hit;
  logic w_to;
  logic w_accept;
  logic w_cap;
  logic w_abort_to;
  logic w_unused;
  pcpi_insn_decode u_dec (
    .i_insn (pcpi_insn),
    .o_match(w_match),
    .o_sel  (w_sel)
  );
  assign w_hit = unit_ready[r_sel];
  assign w_to = r_cnt == CNT_W'(TIMEOUT - 1);
  assign w_unused = &{1'b0, unit_wait};
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = pcpi_valid && w_match ? S_ISSUE : S_IDLE;
      S_ISSUE: w_state_nxt = !pcpi_valid ? S_IDLE : w_hit ? S_RESP : w_to ? S_DRAIN : S_ISSUE;
      S_RESP:  w_state_nxt = S_DRAIN;
      default: w_state_nxt = pcpi_valid ? S_DRAIN : S_IDLE;
    endcase
  end
  assign w_accept = r_state == S_IDLE && w_state_nxt == S_ISSUE;
  assign w_cap = r_state == S_ISSUE && w_state_nxt == S_RESP;
  assign w_abort_to = r_state == S_ISSUE && w_state_nxt == S_DRAIN;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sel <= '0;
      r_cnt <= '0;
      r_rd <= '0;
      r_wr <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_sel <= w_accept ? w_sel : r_sel;
      r_cnt <= w_accept ? '0 : r_state == S_ISSUE ? r_cnt + 1'b1 : r_cnt;
      r_rd <= w_cap ? unit_rd[{r_sel, 5'd0} +: 32] : r_rd;
      r_wr <= w_cap ? unit_wr[r_sel] : r_wr;
      r_err <= w_abort_to ? 1'b1 : err_clr ? 1'b0 : r_err;
    end
  end
  assign unit_valid = r_state == S_ISSUE ? N_UNITS'(1) << r_sel : '0;
  assign pcpi_wait = r_state == S_ISSUE;
  assign pcpi_ready = r_state == S_RESP;
  assign pcpi_rd = pcpi_ready ? r_rd : '0;
  assign pcpi_wr = pcpi_ready & r_wr;
  assign busy = r_state != S_IDLE;
  assign err_timeout = r_err;
endmodule

// File: tb/tb_pcpi_sched.sv
// tb_pcpi_sched: directed checks of pcpi_sched with default and short watchdog instances
module tb_pcpi_sched;
  localparam logic [31:0] I_MUL = {7'b0000001, 5'd6, 5'd7, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] I_DIV = {7'b0000001, 5'd6, 5'd7, 3'b100, 5'd1, 7'b0110011};
  localparam logic [31:0] I_EXACT = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
  localparam logic [31:0] I_APPROX = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [3:0] unit_wr = '0;
  logic [127:0] unit_rd = '0;
  logic [3:0] unit_wait = '0;
  logic [3:0] unit_ready = '0;
  logic err_clr = 1'b0;
  logic a_wr, a_wait, a_ready, a_busy, a_err;
  logic [31:0] a_rd;
  logic [3:0] a_uv;
  logic b_wr, b_wait, b_ready, b_busy, b_err;
  logic [31:0] b_rd;
  logic [3:0] b_uv;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pcpi_sched dut_a (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_wr(a_wr), .pcpi_rd(a_rd), .pcpi_wait(a_wait), .pcpi_ready(a_ready),
    .unit_valid(a_uv), .unit_wr(unit_wr), .unit_rd(unit_rd), .unit_wait(unit_wait),
    .unit_ready(unit_ready), .busy(a_busy), .err_timeout(a_err), .err_clr(err_clr)
  );
  pcpi_sched #(.TIMEOUT(8)) dut_b (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_wr(b_wr), .pcpi_rd(b_rd), .pcpi_wait(b_wait), .pcpi_ready(b_ready),
    .unit_valid(b_uv), .unit_wr(unit_wr), .unit_rd(unit_rd), .unit_wait(unit_wait),
    .unit_ready(unit_ready), .busy(b_busy), .err_timeout(b_err), .err_clr(err_clr)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_a_outs", {a_uv, a_wait, a_ready, a_busy, a_err, a_wr}, 0);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_b_outs", {b_uv, b_wait, b_ready, b_busy, b_err, b_wr}, 0);
    resetn = 1'b1;
    // mul, 33-cycle unit
    pcpi_valid = 1'b1;
    pcpi_insn = I_MUL;
    chk("t1_uv_before", a_uv, 0);
    cyc();
    chk("t1_uv", a_uv, 4'b0001);
    chk("t1_wait", a_wait, 1);
    chk("t1_busy", a_busy, 1);
    repeat (32) cyc();
    chk("t1_wait_k32", a_wait, 1);
    chk("t1_noready_k32", a_ready, 0);
    unit_rd[31:0] = 32'd42;
    unit_wr = 4'b0001;
    unit_ready = 4'b0001;
    cyc();
    chk("t1_ready", a_ready, 1);
    chk("t1_rd", a_rd, 42);
    chk("t1_wr", a_wr, 1);
    chk("t1_wait_resp", a_wait, 0);
    chk("t1_uv_resp", a_uv, 0);
    unit_ready = '0;
    unit_wr = '0;
    cyc();
    chk("t1_ready_drain", a_ready, 0);
    chk("t1_rd_drain", a_rd, 0);
    chk("t1_busy_drain", a_busy, 1);
    chk("t1_b_timed_out", b_err, 1);
    pcpi_valid = 1'b0;
    cyc();
    chk("t1_a_idle", a_busy, 0);
    chk("t1_b_idle", b_busy, 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    // approx_mul, 5-cycle unit, foreign ready ignored
    pcpi_valid = 1'b1;
    pcpi_insn = I_APPROX;
    cyc();
    chk("t2_uv", a_uv, 4'b1000);
    chk("t2_wait_k0", a_wait, 1);
    unit_ready = 4'b0001;
    cyc();
    chk("t2_wait_k1_foreign", a_wait, 1);
    chk("t2_noready_k1", a_ready, 0);
    unit_ready = '0;
    cyc();
    chk("t2_wait_k2", a_wait, 1);
    cyc();
    chk("t2_wait_k3", a_wait, 1);
    cyc();
    chk("t2_wait_k4", a_wait, 1);
    unit_rd[127:96] = 32'hDEAD_BEEF;
    unit_ready = 4'b1000;
    cyc();
    chk("t2_ready", a_ready, 1);
    chk("t2_rd", a_rd, 32'hDEAD_BEEF);
    chk("t2_wr", a_wr, 0);
    chk("t2_wait_resp", a_wait, 0);
    cyc();
    chk("t2_single_pulse", a_ready, 0);
    cyc();
    chk("t2_drain_ignore", {a_ready, a_busy}, 2'b01);
    unit_ready = '0;
    pcpi_valid = 1'b0;
    cyc();
    chk("t2_idle", a_busy, 0);
    unit_ready = 4'b1000;
    cyc();
    chk("t2_idle_ignore", {a_ready, a_busy, a_uv}, 0);
    unit_ready = '0;
    // unknown instruction
    pcpi_valid = 1'b1;
    pcpi_insn = 32'h0000_0013;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t3_quiet", {a_uv, a_wait, a_ready, a_busy}, 0);
    end
    pcpi_valid = 1'b0;
    cyc();
    // div never readies on the TIMEOUT=8 instance
    pcpi_valid = 1'b1;
    pcpi_insn = I_DIV;
    cyc();
    chk("t4_uv", b_uv, 4'b0010);
    repeat (6) cyc();
    chk("t4_uv_k6", b_uv, 4'b0010);
    chk("t4_err_k6", b_err, 0);
    cyc();
    chk("t4_uv_k7", b_uv, 4'b0010);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t4_uv_drop", b_uv, 0);
    chk("t4_wait_drop", b_wait, 0);
    chk("t4_err_set_wins", b_err, 1);
    chk("t4_busy", b_busy, 1);
    chk("t4_noready", b_ready, 0);
    repeat (3) cyc();
    chk("t4_busy_hold", {b_busy, b_ready}, 2'b10);
    chk("t4_a_still_issue", a_wait, 1);
    pcpi_valid = 1'b0;
    cyc();
    chk("t4_b_idle", b_busy, 0);
    chk("t4_err_sticky", b_err, 1);
    chk("t4_a_abort", {a_busy, a_ready, a_uv}, 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t4_err_clr", b_err, 0);
    // ready coincides with the final watchdog cycle
    pcpi_valid = 1'b1;
    pcpi_insn = I_MUL;
    cyc();
    repeat (7) cyc();
    chk("t5_noready_k7", b_ready, 0);
    unit_rd[31:0] = 32'd99;
    unit_wr = 4'b0001;
    unit_ready = 4'b0001;
    cyc();
    chk("t5_ready", b_ready, 1);
    chk("t5_rd", b_rd, 99);
    chk("t5_wr", b_wr, 1);
    chk("t5_err", b_err, 0);
    unit_ready = '0;
    unit_wr = '0;
    cyc();
    chk("t5_err_drain", b_err, 0);
    pcpi_valid = 1'b0;
    cyc();
    // core abort mid-ISSUE
    pcpi_valid = 1'b1;
    pcpi_insn = I_EXACT;
    cyc();
    chk("t5_exact_uv", a_uv, 4'b0100);
    cyc();
    pcpi_valid = 1'b0;
    cyc();
    chk("t5_abort_idle", {a_busy, a_uv, a_wait}, 0);
    cyc();
    chk("t5_abort_noresp", a_ready, 0);
    // single-cycle unit
    pcpi_valid = 1'b1;
    cyc();
    unit_rd[95:64] = 32'd7;
    unit_wr = 4'b0100;
    unit_ready = 4'b0100;
    cyc();
    chk("t5_1cyc_ready", a_ready, 1);
    chk("t5_1cyc_rd", a_rd, 7);
    unit_ready = '0;
    unit_wr = '0;
    cyc();
    pcpi_valid = 1'b0;
    cyc();
    // asynchronous reset mid-ISSUE
    pcpi_valid = 1'b1;
    pcpi_insn = I_MUL;
    cyc();
    cyc();
    chk("t6_pre_reset", a_wait, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_outs", {a_uv, a_wait, a_ready, a_busy, a_err, a_wr}, 0);
    chk("t6_async_rd", a_rd, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    chk("t6_idle", a_busy, 0);
    cyc();
    chk("t6_uv", a_uv, 4'b0001);
    unit_rd[31:0] = 32'd42;
    unit_wr = 4'b0001;
    unit_ready = 4'b0001;
    cyc();
    chk("t6_ready", a_ready, 1);
    chk("t6_rd", a_rd, 42);
    unit_ready = '0;
    unit_wr = '0;
    cyc();
    pcpi_valid = 1'b0;
    cyc();
    chk("t6_final_idle", a_busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
